// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller.
//   state_t   : frame FSM state encoding (3-bit)
//   err_t     : error codes reported on o_err_code
//   SYNC_BYTE_DEF : default frame start marker
//   chk_sum() : frame checksum, (addr + data) mod 256
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CHK  = 2'd1,
        ERR_ADDR = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic logic [7:0] chk_sum(input logic [7:0] a, input logic [7:0] d);
        return a + d;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_reg_bank.sv
// uart_reg_bank: NREG x 8-bit configuration register bank.
//   clk, rst (async, active-low)  : clock / reset, all registers clear to 0
//   i_wr_stb, i_wr_addr, i_wr_data : single write port
//   o_q                            : flattened bank, reg i at [8i+7:8i]
module uart_reg_bank #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_stb,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic [NREG*8-1:0] o_q
);

    logic [NREG-1:0][7:0] r_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_mem <= '0;
        else if (i_wr_stb)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_q = r_mem;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences UART bytes through a SYNC/ADDR/DATA/CHK frame and
// commits each valid frame as one write into the config register bank.
//   clk, rst (async, active-low)
//   i_rx_irq, i_rx_data   : byte strobe / byte from the UART receiver
//   o_wr_stb/addr/data    : committed write (one-cycle strobe)
//   o_reg_q               : flattened register bank
//   o_frame_err, o_err_code : reject pulse / sticky last error code
//   o_frame_cnt           : committed frame count (wraps)
//   o_busy                : FSM not in IDLE
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          TIMEOUT  = 50000,
    parameter int          NREG     = 8,
    localparam int         AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_irq,
    input  logic [7:0]        i_rx_data,
    output logic              o_wr_stb,
    output logic [AW-1:0]     o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [NREG*8-1:0] o_reg_q,
    output logic              o_frame_err,
    output logic [1:0]        o_err_code,
    output logic [7:0]        o_frame_cnt,
    output logic              o_busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        r_state, w_state_nx;
    logic          r_rx_irq_d;
    logic [7:0]    r_addr, r_data;
    logic [TW-1:0] r_tmo;
    logic          r_wr_stb, r_frame_err, r_busy;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data, r_frame_cnt;
    err_t          r_err_code;

    logic w_ev, w_tmo_hit, w_lat_addr, w_lat_data, w_commit, w_err, w_in_frame;
    err_t w_err_code;

    assign w_ev       = i_rx_irq & ~r_rx_irq_d;
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_lat_addr = 1'b0;
        w_lat_data = 1'b0;
        w_commit   = 1'b0;
        w_err      = 1'b0;
        w_err_code = r_err_code;
        case (r_state)
            // COMMIT also watches for SYNC so a new frame can start at once
            ST_IDLE, ST_COMMIT: begin
                w_commit   = (r_state == ST_COMMIT);
                w_state_nx = (w_ev && i_rx_data == SYNC_BYTE) ? ST_ADDR : ST_IDLE;
            end
            ST_ADDR, ST_DATA, ST_CHK: begin
                // a byte arriving on the expiry cycle takes priority
                if (w_ev) begin
                    if (r_state == ST_ADDR) begin
                        w_lat_addr = 1'b1;
                        w_state_nx = ST_DATA;
                    end else if (r_state == ST_DATA) begin
                        w_lat_data = 1'b1;
                        w_state_nx = ST_CHK;
                    end else if (i_rx_data != chk_sum(r_addr, r_data)) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CHK;
                        w_state_nx = ST_IDLE;
                    end else if ({1'b0, r_addr} >= 9'(NREG)) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_ADDR;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_COMMIT;
                    end
                end else if (w_tmo_hit) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TMO;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_irq_d  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tmo       <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_irq_d <= i_rx_irq;
            if (w_lat_addr) r_addr <= i_rx_data;
            if (w_lat_data) r_data <= i_rx_data;
            // clearing on error too keeps the counter from passing TIMEOUT-1
            if (w_ev || !w_in_frame || w_err) r_tmo <= '0;
            else                              r_tmo <= r_tmo + 1'b1;
            r_wr_stb <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_addr[AW-1:0];
                r_wr_data <= r_data;
            end
            r_frame_err <= w_err;
            if (w_err) r_err_code <= w_err_code;
            // counted alongside the bank write so both update on the same edge
            if (r_wr_stb) r_frame_cnt <= r_frame_cnt + 1'b1;
            r_busy <= (w_state_nx != ST_IDLE);
        end
    end

    uart_reg_bank #(.NREG(NREG), .AW(AW)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_stb  (r_wr_stb),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (r_wr_data),
        .o_q       (o_reg_q)
    );

    assign o_wr_stb    = r_wr_stb;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_frame_err = r_frame_err;
    assign o_err_code  = r_err_code;
    assign o_frame_cnt = r_frame_cnt;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

    localparam int TMO  = 40;
    localparam int NREG = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rx_irq = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            wr_stb, frame_err, busy;
    logic [2:0]      wr_addr;
    logic [7:0]      wr_data, frame_cnt;
    logic [1:0]      err_code;
    logic [NREG*8-1:0] reg_q;

    int n_pass = 0, n_tot = 0, n_wr = 0, n_err = 0;

    uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_irq    (rx_irq),
        .i_rx_data   (rx_data),
        .o_wr_stb    (wr_stb),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_reg_q     (reg_q),
        .o_frame_err (frame_err),
        .o_err_code  (err_code),
        .o_frame_cnt (frame_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb)    n_wr++;
        if (frame_err) n_err++;
    end

    typedef struct {
        logic [7:0] a, d, c;
        bit         exp_wr, exp_err;
        logic [1:0] exp_code;
        int         ridx;
        logic [7:0] rval, cnt;
    } vec_t;

    vec_t vt[9];

    function automatic logic [7:0] rq(input int i);
        return reg_q[i*8 +: 8];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_irq  = 1'b1;
        repeat (hold) @(negedge clk);
        rx_irq = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int hold);
        send_byte(8'hA5, hold);
        send_byte(a, hold);
        send_byte(d, hold);
        send_byte(c, hold);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int w0, e0, k;
        vt[0] = '{8'h03, 8'h5C, 8'h5F, 1'b1, 1'b0, 2'd0, 3, 8'h5C, 8'd1};
        vt[1] = '{8'h03, 8'h5C, 8'h60, 1'b0, 1'b1, 2'd1, 3, 8'h5C, 8'd1};
        vt[2] = '{8'h09, 8'h11, 8'h1A, 1'b0, 1'b1, 2'd2, 3, 8'h5C, 8'd1};
        vt[3] = '{8'h07, 8'hFF, 8'h06, 1'b1, 1'b0, 2'd2, 7, 8'hFF, 8'd2};
        vt[4] = '{8'h00, 8'hA5, 8'hA5, 1'b1, 1'b0, 2'd2, 0, 8'hA5, 8'd3};
        vt[5] = '{8'h05, 8'h80, 8'h84, 1'b0, 1'b1, 2'd1, 5, 8'h00, 8'd3};
        vt[6] = '{8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 2'd2, 7, 8'hFF, 8'd3};
        vt[7] = '{8'h09, 8'h10, 8'h00, 1'b0, 1'b1, 2'd1, 0, 8'hA5, 8'd3};
        vt[8] = '{8'h05, 8'hA5, 8'hAA, 1'b1, 1'b0, 2'd1, 5, 8'hA5, 8'd4};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_wr_stb", 32'(wr_stb), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_reg_q", (reg_q == '0) ? 32'd1 : 32'd0, 1);
        rst = 1'b1;

        // table-driven frames
        for (int i = 0; i < 9; i++) begin
            w0 = n_wr; e0 = n_err;
            send_frame(vt[i].a, vt[i].d, vt[i].c, 1);
            check($sformatf("v%0d_wr", i), 32'(n_wr - w0), 32'(vt[i].exp_wr));
            check($sformatf("v%0d_err", i), 32'(n_err - e0), 32'(vt[i].exp_err));
            check($sformatf("v%0d_code", i), 32'(err_code), 32'(vt[i].exp_code));
            check($sformatf("v%0d_reg", i), 32'(rq(vt[i].ridx)), 32'(vt[i].rval));
            check($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(vt[i].cnt));
            check($sformatf("v%0d_busy", i), 32'(busy), 0);
            if (vt[i].exp_wr) begin
                check($sformatf("v%0d_waddr", i), 32'(wr_addr), 32'(vt[i].a[2:0]));
                check($sformatf("v%0d_wdata", i), 32'(wr_data), 32'(vt[i].d));
            end
        end

        // commit timing: A5 06 5C 62
        send_byte(8'hA5, 1); send_byte(8'h06, 1); send_byte(8'h5C, 1);
        @(negedge clk); rx_data = 8'h62; rx_irq = 1'b1;
        @(negedge clk); rx_irq = 1'b0;
        check("cmt_c1_stb", 32'(wr_stb), 0);
        check("cmt_c1_busy", 32'(busy), 1);
        @(negedge clk);
        check("cmt_c2_stb", 32'(wr_stb), 1);
        check("cmt_c2_addr", 32'(wr_addr), 6);
        check("cmt_c2_reg", 32'(rq(6)), 0);
        check("cmt_c2_busy", 32'(busy), 0);
        @(negedge clk);
        check("cmt_c3_stb", 32'(wr_stb), 0);
        check("cmt_c3_reg", 32'(rq(6)), 32'h5C);
        check("cmt_c3_cnt", 32'(frame_cnt), 5);

        // error timing: A5 0A 5C 66 -> address error
        send_byte(8'hA5, 1); send_byte(8'h0A, 1); send_byte(8'h5C, 1);
        @(negedge clk); rx_data = 8'h66; rx_irq = 1'b1;
        check("err_c0_code", 32'(err_code), 1);
        @(negedge clk); rx_irq = 1'b0;
        check("err_c1_ferr", 32'(frame_err), 1);
        check("err_c1_code", 32'(err_code), 2);
        @(negedge clk);
        check("err_c2_ferr", 32'(frame_err), 0);
        repeat (3) @(negedge clk);

        // timeout: A5 02 then silence
        send_byte(8'hA5, 1); send_byte(8'h02, 1);
        k = 0;
        while (!frame_err && k < TMO + 10) begin
            @(negedge clk);
            k++;
            if (k == TMO - 1) check("tmo_busy_before", 32'(busy), 1);
        end
        check("tmo_latency", 32'(k), 32'(TMO));
        check("tmo_code", 32'(err_code), 3);
        check("tmo_busy_after", 32'(busy), 0);
        w0 = n_wr;
        send_frame(8'h02, 8'h33, 8'h35, 1);
        check("tmo_recover_reg", 32'(rq(2)), 32'h33);
        check("tmo_recover_wr", 32'(n_wr - w0), 1);

        // byte event on the expiry cycle wins
        e0 = n_err;
        send_byte(8'hA5, 1); send_byte(8'h02, 1);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h44, 1);
        send_byte(8'h46, 1);
        repeat (4) @(negedge clk);
        check("race_no_err", 32'(n_err - e0), 0);
        check("race_reg", 32'(rq(2)), 32'h44);
        check("race_code", 32'(err_code), 3);

        // reset mid-frame
        send_byte(8'hA5, 1); send_byte(8'h04, 1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_cnt", 32'(frame_cnt), 0);
        check("mrst_code", 32'(err_code), 0);
        check("mrst_wdata", 32'(wr_data), 0);
        check("mrst_waddr", 32'(wr_addr), 0);
        check("mrst_reg_q", (reg_q == '0) ? 32'd1 : 32'd0, 1);
        rst = 1'b1;
        send_frame(8'h04, 8'h22, 8'h26, 1);
        check("mrst_reg4", 32'(rq(4)), 32'h22);
        check("mrst_cnt1", 32'(frame_cnt), 1);

        // leading junk, every byte held 3 cycles
        do_reset();
        w0 = n_wr;
        send_byte(8'h00, 3); send_byte(8'hFF, 3); send_byte(8'h5A, 3);
        send_frame(8'h01, 8'h10, 8'h11, 3);
        check("junk_wr", 32'(n_wr - w0), 1);
        check("junk_reg1", 32'(rq(1)), 32'h10);
        check("junk_cnt", 32'(frame_cnt), 1);
        check("junk_reg0", 32'(rq(0)), 0);

        // frame counter wrap: 255 more commits -> 0
        for (int i = 0; i < 255; i++)
            send_frame(8'h00, 8'(i), 8'(i), 1);
        check("wrap_cnt", 32'(frame_cnt), 0);
        check("wrap_reg0", 32'(rq(0)), 32'hFE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
